sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Single-port SDRAM command scheduler that shares the framebuffer memory between the video refresh path and one pixel writer. It issues fixed-length burst reads to keep the VGA pixel FIFO fed during each frame, and interleaves writer bursts under a bounded-starvation rule. It sits between the SDRAM controller's command interface, the video FIFO (write side), and the picture writer, all in the pixel clock domain.

## Interface
- `ADDR_W`, 24: word address width.
- `BURST_LEN`, 8: words per burst, power of two, at least 2.
- `FIFO_DEPTH`, 512: video FIFO capacity in words.
- `LOW_WATER`, 256: video burst requested while FIFO level is below this. Legal range is BURST_LEN up to FIFO_DEPTH-BURST_LEN.
- `MAX_WAIT`, 4: consecutive video grants a pending writer tolerates before it is forced through. Must be at least 1.
- `clk_i` in 1: pixel clock; the single clock.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `frame_start_i` in 1: one-cycle pulse at frame boundary (VGA end-of-frame).
- `fb_base_i` in ADDR_W: framebuffer base word address. Sampled on `frame_start_i`.
- `frame_words_i` in ADDR_W: words per frame, a multiple of BURST_LEN. Sampled on `frame_start_i`.
- `fifo_level_i` in $clog2(FIFO_DEPTH+1): current video FIFO fill level.
- `wr_req_i` in 1: writer requests one burst. Held until granted.
- `wr_addr_i` in ADDR_W: writer burst start address. Stable while `wr_req_i` is high.
- `wr_gnt_o` out 1: one-cycle pulse when the writer's command is accepted.
- `mem_cmd_valid_o` out 1: command valid to SDRAM controller.
- `mem_cmd_ready_i` in 1: controller accepts command.
- `mem_cmd_we_o` out 1: 1 = write burst, 0 = read burst.
- `mem_cmd_addr_o` out ADDR_W: burst start address.
- `mem_done_i` in 1: one-cycle pulse when the accepted burst has fully completed.
- `vid_active_o` out 1: video fetch for the current frame is incomplete.
- `wr_starved_o` out 1: the writer is being forced through this arbitration.

## Operation
- State machine with three states:
  - IDLE: arbitrate. Move to CMD if any request is eligible.
  - CMD: `mem_cmd_valid_o`=1. Move to WAIT on `mem_cmd_valid_o && mem_cmd_ready_i`.
  - WAIT: move to IDLE on `mem_done_i`.
- At most one burst is outstanding at any time.
- Video eligibility: `vid_active_o && fifo_level_i < LOW_WATER`. The LOW_WATER bound guarantees room for one more burst.
- Writer eligibility: `wr_req_i`.
- Priority:
  - Video wins by default.
  - The writer wins if video is not eligible, or if `wait_cnt == MAX_WAIT`.
  - `wait_cnt` increments on each video grant made while `wr_req_i` is high.
  - `wait_cnt` clears on any writer grant, or when `wr_req_i` is low at an IDLE arbitration.
  - `wait_cnt` saturates at MAX_WAIT.
- `wr_starved_o` is 1 in CMD/WAIT of a writer burst that was won because `wait_cnt == MAX_WAIT`.
- Video address tracking:
  - `vid_ptr` is the offset from the latched base.
  - The command address is `base + vid_ptr`, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - `vid_ptr` advances by BURST_LEN on video command acceptance.
  - `vid_active_o` clears when `vid_ptr` reaches the latched `frame_words`.
- `frame_start_i` sets `vid_active_o`=1, `vid_ptr`=0, and latches base and words.
  - If `frame_start_i` arrives in CMD or WAIT, the burst in progress completes unchanged, and the new pointer applies to the next video command.
  - If `frame_start_i` coincides with a video acceptance, `frame_start_i` wins: `vid_ptr`=0, not BURST_LEN.
- `frame_words_i`=0 leaves `vid_active_o` cleared after `frame_start_i`.
- Command fields (`we`, `addr`) are registered on entering CMD and held stable until accepted.
- `mem_done_i` outside WAIT is ignored.
- Reset values: state IDLE; all outputs 0; `vid_ptr`=0; latched base=0, words=0; `wait_cnt`=0.

## Timing
- Eligible request seen in IDLE at cycle N → `mem_cmd_valid_o`=1 from cycle N+1.
- Acceptance at cycle M → WAIT from M+1. `wr_gnt_o` pulses in cycle M+1 for writer commands.
- `mem_done_i` at cycle D → IDLE at D+1. The next command can be valid at D+2.
- `vid_active_o` updates the cycle after the causing event (`frame_start_i` or final acceptance).
- `fifo_level_i` is sampled only in IDLE. The FIFO's write latency is covered by the LOW_WATER bound.
- Async reset: outputs drop to 0 immediately. Any controller burst in flight is abandoned; the controller is reset by the same `rst_ni`.

## Test plan
- `frame_start_i` with base=0x1000, words=32, level=0, ready=1, done 3 cycles after accept, no writer → exactly 4 reads at 0x1000, 0x1008, 0x1010, 0x1018; then `vid_active_o`=0.
- Level held at 300 (≥ LOW_WATER), frame active → no read issued. Level drops to 255 → read issued 1 cycle later.
- Writer requesting continuously, video always eligible, MAX_WAIT=4 → grant pattern V V V V W(`wr_starved_o`=1) V V V V W …
- `mem_cmd_ready_i` held low 10 cycles with `mem_cmd_valid_o` high → address and `we` stable all 10 cycles; a single acceptance.
- `frame_start_i` during WAIT of the read at 0x1010, new base 0x2000 → in-flight read completes; next read is at 0x2000.
- `rst_ni` low mid-CMD → `mem_cmd_valid_o`=0 asynchronously. After release, no command until `frame_start_i` or `wr_req_i`.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_port_arbiter : burst scheduler sharing SDRAM between video and writer
// Rev 1.0
// ============================================================================
module sdram_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 512,
  parameter int LOW_WATER  = 256,
  parameter int MAX_WAIT   = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            frame_start_i,
  input  logic [ADDR_W-1:0]               fb_base_i,
  input  logic [ADDR_W-1:0]               frame_words_i,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_i,
  input  logic                            wr_req_i,
  input  logic [ADDR_W-1:0]               wr_addr_i,
  output logic                            wr_gnt_o,
  output logic                            mem_cmd_valid_o,
  input  logic                            mem_cmd_ready_i,
  output logic                            mem_cmd_we_o,
  output logic [ADDR_W-1:0]               mem_cmd_addr_o,
  input  logic                            mem_done_i,
  output logic                            vid_active_o,
  output logic                            wr_starved_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int WC_W  = $clog2(MAX_WAIT+1);
  localparam logic [LVL_W-1:0]  C_LOW_WATER = LVL_W'(LOW_WATER);
  localparam logic [WC_W-1:0]   C_MAX_WAIT  = WC_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] C_BURST     = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_vid_active;
  logic [ADDR_W-1:0] r_vid_ptr;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_words;
  logic [WC_W-1:0]   r_wait_cnt;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic              r_cmd_stale;
  logic              r_starved;
  logic              r_wr_gnt;

  logic              w_vid_elig;
  logic              w_force;
  logic              w_pick_wr;
  logic              w_pick_vid;
  logic              w_accept;
  logic [ADDR_W-1:0] w_ptr_next;

  assign w_vid_elig = r_vid_active && (fifo_level_i < C_LOW_WATER);
  assign w_force    = (r_wait_cnt == C_MAX_WAIT);
  assign w_pick_wr  = wr_req_i && (!w_vid_elig || w_force);
  assign w_pick_vid = w_vid_elig && !w_pick_wr;
  assign w_accept   = (r_state == S_CMD) && mem_cmd_ready_i;
  assign w_ptr_next = r_vid_ptr + C_BURST;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    mem_cmd_valid_o = 1'b0;
    wr_starved_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_wr || w_pick_vid) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        mem_cmd_valid_o = 1'b1;
        wr_starved_o    = r_starved;
        if (mem_cmd_ready_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        wr_starved_o = r_starved;
        if (mem_done_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A frame restart while a video command is pending marks that command stale,
  // so its acceptance does not advance the freshly reset pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vid_active <= 1'b0;
      r_vid_ptr    <= '0;
      r_base       <= '0;
      r_words      <= '0;
      r_wait_cnt   <= '0;
      r_cmd_we     <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_stale  <= 1'b0;
      r_starved    <= 1'b0;
      r_wr_gnt     <= 1'b0;
    end else begin
      r_wr_gnt <= w_accept && r_cmd_we;

      if (r_state == S_IDLE) begin
        if (w_pick_wr) begin
          r_cmd_we    <= 1'b1;
          r_cmd_addr  <= wr_addr_i;
          r_starved   <= w_force && w_vid_elig;
          r_cmd_stale <= 1'b0;
          r_wait_cnt  <= '0;
        end else if (w_pick_vid) begin
          r_cmd_we    <= 1'b0;
          r_cmd_addr  <= r_base + r_vid_ptr;
          r_starved   <= 1'b0;
          r_cmd_stale <= frame_start_i;
          if (wr_req_i && !w_force) r_wait_cnt <= r_wait_cnt + WC_W'(1);
        end
        if (!wr_req_i) r_wait_cnt <= '0;
      end else if (r_state == S_CMD && frame_start_i) begin
        r_cmd_stale <= 1'b1;
      end

      if (frame_start_i) begin
        r_base       <= fb_base_i;
        r_words      <= frame_words_i;
        r_vid_ptr    <= '0;
        r_vid_active <= |frame_words_i;
      end else if (w_accept && !r_cmd_we && !r_cmd_stale) begin
        r_vid_ptr <= w_ptr_next;
        if (w_ptr_next == r_words) r_vid_active <= 1'b0;
      end
    end
  end

  assign wr_gnt_o       = r_wr_gnt;
  assign mem_cmd_we_o   = r_cmd_we;
  assign mem_cmd_addr_o = r_cmd_addr;
  assign vid_active_o   = r_vid_active;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sdram_port_arbiter : scenario tasks plus randomized queue-based model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int ADDR_W     = 24;
  localparam int BURST_LEN  = 8;
  localparam int FIFO_DEPTH = 512;
  localparam int LOW_WATER  = 256;
  localparam int MAX_WAIT   = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH+1);

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              frame_start_i = 1'b0;
  logic [ADDR_W-1:0] fb_base_i = '0;
  logic [ADDR_W-1:0] frame_words_i = '0;
  logic [LVL_W-1:0]  fifo_level_i = '0;
  logic              wr_req_i = 1'b0;
  logic [ADDR_W-1:0] wr_addr_i = '0;
  logic              wr_gnt_o;
  logic              mem_cmd_valid_o;
  logic              mem_cmd_ready_i = 1'b0;
  logic              mem_cmd_we_o;
  logic [ADDR_W-1:0] mem_cmd_addr_o;
  logic              mem_done_i = 1'b0;
  logic              vid_active_o;
  logic              wr_starved_o;

  int n_vec = 0;
  int n_bad = 0;

  bit auto_resp = 1'b0;
  int rdy_pct   = 100;
  int done_dly  = 3;
  int dcnt      = 0;
  logic [ADDR_W-1:0] log_addr[$];
  bit                log_we[$];
  bit                log_starv[$];

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH),
    .LOW_WATER(LOW_WATER), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .frame_start_i(frame_start_i),
    .fb_base_i(fb_base_i), .frame_words_i(frame_words_i),
    .fifo_level_i(fifo_level_i), .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i),
    .wr_gnt_o(wr_gnt_o), .mem_cmd_valid_o(mem_cmd_valid_o),
    .mem_cmd_ready_i(mem_cmd_ready_i), .mem_cmd_we_o(mem_cmd_we_o),
    .mem_cmd_addr_o(mem_cmd_addr_o), .mem_done_i(mem_done_i),
    .vid_active_o(vid_active_o), .wr_starved_o(wr_starved_o)
  );

  always #5 clk_i = ~clk_i;

  // Called at a falling edge: plays the controller, logs acceptances, advances one cycle.
  task automatic tick();
    if (auto_resp) begin
      mem_done_i = (dcnt == 1);
      if (dcnt > 0) dcnt--;
      mem_cmd_ready_i = ($urandom_range(99) < rdy_pct);
    end
    if (mem_cmd_valid_o && mem_cmd_ready_i) begin
      log_addr.push_back(mem_cmd_addr_o);
      log_we.push_back(mem_cmd_we_o);
      log_starv.push_back(wr_starved_o);
      dcnt = done_dly;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; frame_start_i = 1'b0; fb_base_i = '0; frame_words_i = '0;
    fifo_level_i = '0; wr_req_i = 1'b0; wr_addr_i = '0;
    mem_cmd_ready_i = 1'b0; mem_done_i = 1'b0;
    auto_resp = 1'b0; rdy_pct = 100; done_dly = 3; dcnt = 0;
    log_addr.delete(); log_we.delete(); log_starv.delete();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic start_frame(input logic [ADDR_W-1:0] base, input int words);
    fb_base_i     = base;
    frame_words_i = ADDR_W'(words);
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    frame_start_i = 1'b1; frame_words_i = 24'd64; wr_req_i = 1'b1;
    mem_cmd_ready_i = 1'b1; mem_done_i = 1'b1; fifo_level_i = '0;
    repeat (3) @(negedge clk_i);
    n_vec++; if (mem_cmd_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", mem_cmd_valid_o); end
    n_vec++; if (mem_cmd_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", mem_cmd_we_o); end
    n_vec++; if (mem_cmd_addr_o !== '0) begin n_bad++; $display("FAIL reset_addr got %h want 0", mem_cmd_addr_o); end
    n_vec++; if (wr_gnt_o !== 1'b0) begin n_bad++; $display("FAIL reset_gnt got %b want 0", wr_gnt_o); end
    n_vec++; if (vid_active_o !== 1'b0) begin n_bad++; $display("FAIL reset_active got %b want 0", vid_active_o); end
    n_vec++; if (wr_starved_o !== 1'b0) begin n_bad++; $display("FAIL reset_starved got %b want 0", wr_starved_o); end
    do_reset();
  endtask

  task automatic test_frame_reads();
    do_reset();
    auto_resp = 1'b1; rdy_pct = 100; done_dly = 3; fifo_level_i = '0;
    start_frame(24'h001000, 32);
    n_vec++; if (vid_active_o !== 1'b1) begin n_bad++; $display("FAIL frame_active_rise got %b want 1", vid_active_o); end
    n_vec++; if (mem_cmd_valid_o !== 1'b0) begin n_bad++; $display("FAIL frame_first_latency got %b want 0", mem_cmd_valid_o); end
    tick();
    n_vec++; if (mem_cmd_valid_o !== 1'b1 || mem_cmd_addr_o !== 24'h001000) begin
      n_bad++; $display("FAIL frame_first_cmd got v=%b a=%h want v=1 a=001000", mem_cmd_valid_o, mem_cmd_addr_o);
    end
    for (int t = 0; t < 200 && log_addr.size() < 4; t++) tick();
    repeat (20) tick();
    n_vec++; if (log_addr.size() != 4) begin n_bad++; $display("FAIL frame_read_count got %0d want 4", log_addr.size()); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      logic [ADDR_W-1:0] ea;
      ea = ADDR_W'(32'h1000 + 8 * i);
      n_vec++;
      if (log_addr[i] !== ea || log_we[i] !== 1'b0) begin
        n_bad++; $display("FAIL frame_read_%0d got we=%b a=%h want we=0 a=%h", i, log_we[i], log_addr[i], ea);
      end
    end
    n_vec++; if (vid_active_o !== 1'b0) begin n_bad++; $display("FAIL frame_active_end got %b want 0", vid_active_o); end
  endtask

  task automatic test_low_water();
    do_reset();
    auto_resp = 1'b1; rdy_pct = 100; done_dly = 2;
    fifo_level_i = LVL_W'(300);
    start_frame(24'h003000, 16);
    repeat (20) tick();
    n_vec++; if (log_addr.size() != 0 || mem_cmd_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL lowwater_hold got n=%0d v=%b want n=0 v=0", log_addr.size(), mem_cmd_valid_o);
    end
    fifo_level_i = LVL_W'(LOW_WATER - 1);
    tick();
    n_vec++; if (mem_cmd_valid_o !== 1'b1 || mem_cmd_we_o !== 1'b0 || mem_cmd_addr_o !== 24'h003000) begin
      n_bad++; $display("FAIL lowwater_issue got v=%b we=%b a=%h want v=1 we=0 a=003000",
                        mem_cmd_valid_o, mem_cmd_we_o, mem_cmd_addr_o);
    end
  endtask

  task automatic test_starvation();
    int vidx;
    do_reset();
    auto_resp = 1'b1; rdy_pct = 100; done_dly = 1; fifo_level_i = '0;
    start_frame(24'h040000, 512);
    wr_req_i = 1'b1; wr_addr_i = 24'h0ABC00;
    for (int t = 0; t < 400 && log_addr.size() < 15; t++) tick();
    n_vec++; if (log_addr.size() < 15) begin n_bad++; $display("FAIL starve_count got %0d want 15", log_addr.size()); end
    vidx = 0;
    for (int i = 0; i < 15 && i < log_addr.size(); i++) begin
      bit ew;
      logic [ADDR_W-1:0] ea;
      ew = ((i % 5) == 4);
      ea = ew ? 24'h0ABC00 : ADDR_W'(32'h040000 + 8 * vidx);
      if (!ew) vidx++;
      n_vec++;
      if (log_we[i] !== ew || log_starv[i] !== ew || log_addr[i] !== ea) begin
        n_bad++; $display("FAIL starve_grant_%0d got we=%b st=%b a=%h want we=%b st=%b a=%h",
                          i, log_we[i], log_starv[i], log_addr[i], ew, ew, ea);
      end
    end
    wr_req_i = 1'b0;
  endtask

  task automatic test_ready_stall();
    logic [ADDR_W-1:0] a0;
    logic              w0;
    int                bad;
    do_reset();
    auto_resp = 1'b1; rdy_pct = 0; done_dly = 2; fifo_level_i = '0;
    start_frame(24'h005000, 16);
    for (int t = 0; t < 10 && !mem_cmd_valid_o; t++) tick();
    a0 = mem_cmd_addr_o; w0 = mem_cmd_we_o;
    n_vec++; if (mem_cmd_valid_o !== 1'b1 || a0 !== 24'h005000 || w0 !== 1'b0) begin
      n_bad++; $display("FAIL stall_start got v=%b we=%b a=%h want v=1 we=0 a=005000", mem_cmd_valid_o, w0, a0);
    end
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (mem_cmd_valid_o !== 1'b1 || mem_cmd_addr_o !== a0 || mem_cmd_we_o !== w0) bad++;
    end
    n_vec++; if (bad != 0) begin n_bad++; $display("FAIL stall_stable got %0d unstable cycles want 0", bad); end
    rdy_pct = 100; tick(); rdy_pct = 0;
    repeat (6) tick();
    n_vec++; if (log_addr.size() != 1) begin n_bad++; $display("FAIL stall_accepts got %0d want 1", log_addr.size()); end
  endtask

  task automatic test_frame_restart();
    do_reset();
    auto_resp = 1'b1; rdy_pct = 100; done_dly = 3; fifo_level_i = '0;
    start_frame(24'h001000, 32);
    for (int t = 0; t < 100 && log_addr.size() < 3; t++) tick();
    start_frame(24'h002000, 16);
    for (int t = 0; t < 100 && log_addr.size() < 5; t++) tick();
    n_vec++; if (log_addr.size() < 5) begin n_bad++; $display("FAIL restart_count got %0d want 5", log_addr.size()); end
    else begin
      n_vec++; if (log_addr[2] !== 24'h001010) begin n_bad++; $display("FAIL restart_inflight got %h want 001010", log_addr[2]); end
      n_vec++; if (log_addr[3] !== 24'h002000) begin n_bad++; $display("FAIL restart_next got %h want 002000", log_addr[3]); end
      n_vec++; if (log_addr[4] !== 24'h002008) begin n_bad++; $display("FAIL restart_second got %h want 002008", log_addr[4]); end
    end
    repeat (20) tick();
    n_vec++; if (log_addr.size() != 5 || vid_active_o !== 1'b0) begin
      n_bad++; $display("FAIL restart_end got n=%0d act=%b want n=5 act=0", log_addr.size(), vid_active_o);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    auto_resp = 1'b1; rdy_pct = 0; fifo_level_i = '0;
    start_frame(24'h001000, 32);
    tick();
    n_vec++; if (mem_cmd_valid_o !== 1'b1) begin n_bad++; $display("FAIL areset_pre got %b want 1", mem_cmd_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_vec++; if (mem_cmd_valid_o !== 1'b0 || vid_active_o !== 1'b0) begin
      n_bad++; $display("FAIL areset_drop got v=%b act=%b want 0 0", mem_cmd_valid_o, vid_active_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (mem_cmd_valid_o !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_bad++; $display("FAIL areset_quiet got %0d busy cycles want 0", bad); end
    wr_req_i = 1'b1; wr_addr_i = 24'h000777;
    tick();
    n_vec++; if (mem_cmd_valid_o !== 1'b1 || mem_cmd_we_o !== 1'b1 || mem_cmd_addr_o !== 24'h000777) begin
      n_bad++; $display("FAIL areset_writer got v=%b we=%b a=%h want 1 1 000777", mem_cmd_valid_o, mem_cmd_we_o, mem_cmd_addr_o);
    end
    wr_req_i = 1'b0;
  endtask

  // Model: per-frame queue of expected read addresses, a video-streak counter,
  // and the command handshake phase (0 idle, 1 command offered, 2 awaiting done).
  task automatic test_random();
    int                ph;
    logic [ADDR_W-1:0] q[$];
    bit                pend;
    int                streak;
    bit                cur_we, cur_starv, exp_gnt, exp_act, vok, accept;
    logic [ADDR_W-1:0] cur_addr, waddr, base;
    bit                fs, wr, rdy, dn;
    logic [LVL_W-1:0]  lvl;
    int                words;
    do_reset();
    ph = 0; pend = 1'b0; streak = 0; cur_we = 1'b0; cur_starv = 1'b0; cur_addr = '0;
    wr = 1'b0; waddr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fs = ((ph != 0) || (q.size() == 0)) && ($urandom_range(24) == 0);
      base = ADDR_W'($urandom);
      if ($urandom_range(3) == 0) base = ADDR_W'(24'hFFFFF8 - 8 * $urandom_range(2));
      words = 8 * $urandom_range(6);
      if (!wr && $urandom_range(3) == 0) begin wr = 1'b1; waddr = ADDR_W'($urandom); end
      lvl = $urandom_range(1) ? LVL_W'($urandom_range(LOW_WATER-1))
                              : LVL_W'($urandom_range(FIFO_DEPTH, LOW_WATER));
      rdy = 1'($urandom_range(1));
      dn  = (ph == 2) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      frame_start_i = fs; fb_base_i = base; frame_words_i = ADDR_W'(words);
      wr_req_i = wr; wr_addr_i = waddr; fifo_level_i = lvl;
      mem_cmd_ready_i = rdy; mem_done_i = dn;

      accept  = (ph == 1) && rdy;
      exp_gnt = accept && cur_we;
      case (ph)
        0: begin
          vok = (q.size() > 0) && (lvl < LVL_W'(LOW_WATER));
          if (wr && (!vok || streak == MAX_WAIT)) begin
            ph = 1; cur_we = 1'b1; cur_addr = waddr; cur_starv = vok; streak = 0;
          end else if (vok) begin
            ph = 1; cur_we = 1'b0; cur_addr = q.pop_front(); cur_starv = 1'b0; pend = 1'b1;
            if (wr && streak < MAX_WAIT) streak++;
          end
          if (!wr) streak = 0;
        end
        1: begin
          if (rdy) ph = 2;
          if (accept && !cur_we) pend = 1'b0;
        end
        default: if (dn) ph = 0;
      endcase
      if (fs) begin
        q.delete();
        for (int k = 0; k < words / BURST_LEN; k++) q.push_back(base + ADDR_W'(BURST_LEN * k));
        pend = 1'b0;
      end
      exp_act = (q.size() > 0) || pend;

      @(posedge clk_i);
      @(negedge clk_i);
      if (exp_gnt) wr = 1'b0;

      n_vec++; if (mem_cmd_valid_o !== 1'(ph == 1)) begin
        n_bad++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, mem_cmd_valid_o, ph == 1);
      end
      if (ph == 1) begin
        n_vec++; if (mem_cmd_we_o !== cur_we || mem_cmd_addr_o !== cur_addr) begin
          n_bad++; $display("FAIL rnd_cmd cyc %0d got we=%b a=%h want we=%b a=%h", cyc, mem_cmd_we_o, mem_cmd_addr_o, cur_we, cur_addr);
        end
      end
      n_vec++; if (wr_gnt_o !== exp_gnt) begin
        n_bad++; $display("FAIL rnd_gnt cyc %0d got %b want %b", cyc, wr_gnt_o, exp_gnt);
      end
      n_vec++; if (vid_active_o !== exp_act) begin
        n_bad++; $display("FAIL rnd_active cyc %0d got %b want %b", cyc, vid_active_o, exp_act);
      end
      n_vec++; if (wr_starved_o !== (cur_starv && ph != 0)) begin
        n_bad++; $display("FAIL rnd_starved cyc %0d got %b want %b", cyc, wr_starved_o, cur_starv && ph != 0);
      end
    end
    frame_start_i = 1'b0; wr_req_i = 1'b0; mem_done_i = 1'b0;
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_frame_reads();
    test_low_water();
    test_starvation();
    test_ready_stall();
    test_frame_restart();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
